// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_sequencer
//  Description : Control sequencer for the FFT datapath. It writes one config
//                word to the core and gates N-sample input frames while
//                generating their tlast. It also counts output frames and
//                reports busy/done/aborted/error status. Handshakes only;
//                no sample data passes through this block.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer #(
    parameter int MAX_LOG2 = 12,
    parameter int SCALE_W  = 12,
    parameter int FRAMES_W = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                ctrl_start,
    input  logic                ctrl_abort,
    input  logic [4:0]          cfg_nfft_log2,
    input  logic                cfg_fwd_inv,
    input  logic [SCALE_W-1:0]  cfg_scale_sch,
    input  logic [FRAMES_W-1:0] cfg_num_frames,
    output logic [23:0]         cfg_tdata,
    output logic                cfg_tvalid,
    input  logic                cfg_tready,
    input  logic                src_tvalid,
    output logic                src_tready,
    output logic                fft_in_tvalid,
    input  logic                fft_in_tready,
    output logic                fft_in_tlast,
    input  logic                fft_out_tvalid,
    input  logic                fft_out_tready,
    input  logic                fft_out_tlast,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                err_cfg,
    output logic                err_tlast,
    output logic [FRAMES_W-1:0] frames_out
);

    localparam logic [4:0]          c_MIN_LOG2 = 5'd3;
    localparam logic [4:0]          c_MAX_LOG2 = 5'(MAX_LOG2);
    // Zero padding above the scale field; the config word layout assumes SCALE_W <= 14.
    localparam int                  c_PAD_W    = 24 - 9 - SCALE_W;
    localparam logic [MAX_LOG2-1:0] c_CNT_ONE  = {{(MAX_LOG2-1){1'b0}}, 1'b1};
    localparam logic [FRAMES_W-1:0] c_FRM_ONE  = {{(FRAMES_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONFIG = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_end_abort;

    logic [4:0]          r_nfft_log2;
    logic                r_fwd_inv;
    logic [SCALE_W-1:0]  r_scale_sch;
    logic [FRAMES_W-1:0] r_num_frames;   // becomes the effective frame count after an abort
    logic [MAX_LOG2-1:0] r_in_cnt;
    logic [FRAMES_W-1:0] r_in_frames;
    logic [MAX_LOG2-1:0] r_out_cnt;
    logic [FRAMES_W-1:0] r_frames_out;
    logic                r_done;
    logic                r_aborted;
    logic                r_err_cfg;
    logic                r_err_tlast;

    logic                w_start_ok;
    logic                w_start_acc;
    logic                w_start_rej;
    logic                w_active;
    logic                w_in_en;
    logic                w_in_beat;
    logic                w_in_last;
    logic [MAX_LOG2-1:0] w_in_cnt_nxt;
    logic [FRAMES_W-1:0] w_in_frames_nxt;
    logic                w_out_beat;
    logic                w_out_last;
    logic                w_out_wrap;
    logic [FRAMES_W-1:0] w_frames_out_nxt;
    logic [FRAMES_W-1:0] w_abort_target;
    logic                w_complete;
    logic [MAX_LOG2-1:0] w_last_idx;
    logic [23:0]         w_cfg_word;

    // N-1 as a mask of nfft_log2 ones; a shift of MAX_LOG2 clears every bit.
    assign w_last_idx = ~({MAX_LOG2{1'b1}} << r_nfft_log2);

    assign w_start_ok  = (cfg_nfft_log2 >= c_MIN_LOG2) && (cfg_nfft_log2 <= c_MAX_LOG2) &&
                         (cfg_num_frames != '0);
    assign w_start_acc = ctrl_start && (r_state == S_IDLE) && w_start_ok;
    assign w_start_rej = ctrl_start && (r_state == S_IDLE) && !w_start_ok;

    assign w_active  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_in_en   = w_active && (r_in_frames != r_num_frames);
    assign w_in_beat = src_tvalid && fft_in_tready && w_in_en;
    assign w_in_last = (r_in_cnt == w_last_idx);

    assign w_in_cnt_nxt    = !w_in_beat ? r_in_cnt : (w_in_last ? '0 : r_in_cnt + c_CNT_ONE);
    assign w_in_frames_nxt = (w_in_beat && w_in_last) ? r_in_frames + c_FRM_ONE : r_in_frames;

    assign w_out_beat       = w_active && fft_out_tvalid && fft_out_tready;
    assign w_out_last       = (r_out_cnt == w_last_idx);
    assign w_out_wrap       = w_out_beat && w_out_last;
    assign w_frames_out_nxt = w_out_wrap ? r_frames_out + c_FRM_ONE : r_frames_out;
    assign w_complete       = w_out_wrap && (w_frames_out_nxt == r_num_frames);

    // Frames that will have entered the core once any partial frame (including a beat
    // accepted in the abort cycle itself) is allowed to finish.
    assign w_abort_target = w_in_frames_nxt + ((w_in_cnt_nxt != '0) ? c_FRM_ONE : '0);

    assign w_cfg_word    = {{c_PAD_W{1'b0}}, r_scale_sch, r_fwd_inv, 3'b000, r_nfft_log2};
    assign cfg_tvalid    = (r_state == S_CONFIG);
    assign cfg_tdata     = cfg_tvalid ? w_cfg_word : '0;
    assign fft_in_tvalid = src_tvalid && w_in_en;
    assign src_tready    = fft_in_tready && w_in_en;
    assign fft_in_tlast  = w_in_en && w_in_last;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign aborted       = r_aborted;
    assign err_cfg       = r_err_cfg;
    assign err_tlast     = r_err_tlast;
    assign frames_out    = r_frames_out;

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state selection; normal completion takes priority over a coincident abort.
    always_comb begin
        w_state_nxt = r_state;
        w_end_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) w_state_nxt = S_CONFIG;
            end
            S_CONFIG: begin
                if (ctrl_abort) begin
                    w_state_nxt = S_DONE;
                    w_end_abort = 1'b1;
                end else if (cfg_tready) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_complete) begin
                    w_state_nxt = S_DONE;
                end else if (ctrl_abort) begin
                    if (w_abort_target == w_frames_out_nxt) begin
                        w_state_nxt = S_DONE;
                        w_end_abort = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_frames_out_nxt == r_num_frames) begin
                    w_state_nxt = S_DONE;
                    w_end_abort = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Config latch, beat counters and sticky status flags.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_nfft_log2  <= '0;
            r_fwd_inv    <= 1'b0;
            r_scale_sch  <= '0;
            r_num_frames <= '0;
            r_in_cnt     <= '0;
            r_in_frames  <= '0;
            r_out_cnt    <= '0;
            r_frames_out <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_err_cfg    <= 1'b0;
            r_err_tlast  <= 1'b0;
        end else if (w_start_acc) begin
            r_nfft_log2  <= cfg_nfft_log2;
            r_fwd_inv    <= cfg_fwd_inv;
            r_scale_sch  <= cfg_scale_sch;
            r_num_frames <= cfg_num_frames;
            r_in_cnt     <= '0;
            r_in_frames  <= '0;
            r_out_cnt    <= '0;
            r_frames_out <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_err_cfg    <= 1'b0;
            r_err_tlast  <= 1'b0;
        end else begin
            if (w_start_rej) r_err_cfg <= 1'b1;
            if (w_in_beat) begin
                r_in_cnt    <= w_in_cnt_nxt;
                r_in_frames <= w_in_frames_nxt;
            end
            if (w_out_beat) begin
                r_out_cnt    <= w_out_last ? '0 : r_out_cnt + c_CNT_ONE;
                r_frames_out <= w_frames_out_nxt;
                if (fft_out_tlast != w_out_last) r_err_tlast <= 1'b1;
            end
            if ((r_state == S_RUN) && ctrl_abort && !w_complete) r_num_frames <= w_abort_target;
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
                r_done <= 1'b1;
                if (w_end_abort) r_aborted <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
